// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS checker (x^TAPB + x^TAPA + 1).
// It locks after a full history fill plus a run of matches, then counts line errors against a free-running reference.
module prbs_checker #(
    parameter int TAPB          = 31,
    parameter int TAPA          = 28,
    parameter int LOCK_COUNT    = 64,
    parameter int WINDOW        = 256,
    parameter int UNLOCK_ERRORS = 16,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     valid,
    input  logic                     bit_in,
    input  logic                     clear_counters,
    output logic                     locked,
    output logic                     error,
    output logic                     lock_lost,
    output logic [COUNTER_WIDTH-1:0] bit_count,
    output logic [COUNTER_WIDTH-1:0] error_count,
    output logic                     saturated
);
    localparam int CW = COUNTER_WIDTH;
    localparam int FW = $clog2(TAPB + 1);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(UNLOCK_ERRORS + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t          state, state_next;
    logic [TAPB-1:0] s;
    logic [FW-1:0]   fill;
    logic [RW-1:0]   run, run_next;
    logic [WW-1:0]   win_bits, win_bits_inc;
    logic [EW-1:0]   win_errs, win_errs_inc;
    logic            p, mismatch, filled, match, lock_hit, unlock_hit, win_end;
    logic            inc_bits, inc_errs;
    logic [CW-1:0]   bit_count_next, error_count_next;

    assign p        = s[TAPA-1] ^ s[TAPB-1];
    assign mismatch = bit_in != p;

    always_comb begin
        filled           = fill == FW'(TAPB);
        // An all-zero history would predict zeros forever, so it never counts as a match.
        match            = filled && !mismatch && (s != '0);
        run_next         = match ? run + RW'(1) : '0;
        win_bits_inc     = win_bits + WW'(1);
        win_errs_inc     = win_errs + EW'(mismatch);
        lock_hit         = valid && state == SEARCH && run_next == RW'(LOCK_COUNT);
        unlock_hit       = valid && state == LOCKED && win_errs_inc == EW'(UNLOCK_ERRORS);
        win_end          = win_bits_inc == WW'(WINDOW);
        state_next       = lock_hit ? LOCKED : unlock_hit ? SEARCH : state;
        inc_bits         = valid && state == LOCKED;
        inc_errs         = inc_bits && mismatch;
        bit_count_next   = clear_counters ? '0 : (inc_bits && !(&bit_count)) ? bit_count + CW'(1) : bit_count;
        error_count_next = clear_counters ? '0 : (inc_errs && !(&error_count)) ? error_count + CW'(1) : error_count;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= SEARCH;
            s           <= '0;
            fill        <= '0;
            run         <= '0;
            win_bits    <= '0;
            win_errs    <= '0;
            locked      <= 1'b0;
            error       <= 1'b0;
            lock_lost   <= 1'b0;
            bit_count   <= '0;
            error_count <= '0;
            saturated   <= 1'b0;
        end else begin
            state       <= state_next;
            locked      <= state_next == LOCKED;
            error       <= inc_errs;
            lock_lost   <= unlock_hit;
            bit_count   <= bit_count_next;
            error_count <= error_count_next;
            saturated   <= !clear_counters && (saturated || (&bit_count_next) || (&error_count_next));
            if (valid) begin
                if (state == SEARCH) begin
                    s        <= {s[TAPB-2:0], bit_in};
                    fill     <= filled ? fill : fill + FW'(1);
                    run      <= lock_hit ? '0 : run_next;
                    win_bits <= '0;
                    win_errs <= '0;
                end else begin
                    // Locked: the reference runs free so a line error corrupts only its own bit.
                    s        <= {s[TAPB-2:0], p};
                    fill     <= unlock_hit ? '0 : fill;
                    run      <= '0;
                    win_bits <= (unlock_hit || win_end) ? '0 : win_bits_inc;
                    win_errs <= (unlock_hit || win_end) ? '0 : win_errs_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: drives PRBS31 streams into two checkers (32-bit and 4-bit counters)
// and compares every cycle against a queue-based reference model plus hand-derived constants.
module tb_prbs_checker;
    localparam int TB = 31, TA = 28, LC = 64, WIN = 256, UE = 16;

    logic clock = 1'b0, reset = 1'b0, valid = 1'b0, bit_in = 1'b0, clear_counters = 1'b0;
    logic locked, error, lock_lost, saturated;
    logic locked4, error4, lock_lost4, saturated4;
    logic [31:0] bit_count, error_count;
    logic [3:0]  bit_count4, error_count4;
    int vectors = 0, miscompares = 0;

    always #5 clock = ~clock;

    prbs_checker dut (
        .clock(clock), .reset(reset), .valid(valid), .bit_in(bit_in), .clear_counters(clear_counters),
        .locked(locked), .error(error), .lock_lost(lock_lost),
        .bit_count(bit_count), .error_count(error_count), .saturated(saturated)
    );

    prbs_checker #(.COUNTER_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .valid(valid), .bit_in(bit_in), .clear_counters(clear_counters),
        .locked(locked4), .error(error4), .lock_lost(lock_lost4),
        .bit_count(bit_count4), .error_count(error_count4), .saturated(saturated4)
    );

    bit        hist[$];
    bit        m_locked, m_err, m_ll;
    int        m_fill, m_run, m_wbits, m_werrs;
    longint    m_bits, m_errs;
    logic [30:0] gen;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (TB) hist.push_back(1'b0);
        m_locked = 0; m_err = 0; m_ll = 0;
        m_fill = 0; m_run = 0; m_wbits = 0; m_werrs = 0;
        m_bits = 0; m_errs = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr);
        bit pr, nz;
        m_err = 0;
        m_ll  = 0;
        if (v) begin
            pr = hist[TA-1] ^ hist[TB-1];
            nz = 0;
            foreach (hist[i]) nz |= hist[i];
            if (!m_locked) begin
                if (m_fill == TB) begin
                    m_run = (b == pr && nz) ? m_run + 1 : 0;
                    if (m_run == LC) begin
                        m_locked = 1; m_run = 0; m_wbits = 0; m_werrs = 0;
                    end
                end else m_fill++;
                hist.push_front(b);
            end else begin
                m_err = b != pr;
                hist.push_front(pr);
                m_bits++;
                m_errs += longint'(m_err);
                m_wbits++;
                m_werrs += int'(m_err);
                if (m_werrs == UE) begin
                    m_locked = 0; m_ll = 1; m_fill = 0; m_run = 0; m_wbits = 0; m_werrs = 0;
                end else if (m_wbits == WIN) begin
                    m_wbits = 0; m_werrs = 0;
                end
            end
            void'(hist.pop_back());
        end
        if (clr) begin
            m_bits = 0; m_errs = 0;
        end
    endtask

    task automatic check_all();
        chk("locked", locked, m_locked);
        chk("error", error, m_err);
        chk("lock_lost", lock_lost, m_ll);
        chk("bit_count", bit_count, m_bits);
        chk("error_count", error_count, m_errs);
        chk("saturated", saturated, longint'(m_bits >= 64'd4294967295 || m_errs >= 64'd4294967295));
        chk("locked4", locked4, m_locked);
        chk("error4", error4, m_err);
        chk("lock_lost4", lock_lost4, m_ll);
        chk("bit_count4", bit_count4, m_bits > 15 ? 15 : m_bits);
        chk("error_count4", error_count4, m_errs > 15 ? 15 : m_errs);
        chk("saturated4", saturated4, longint'(m_bits >= 15 || m_errs >= 15));
    endtask

    task automatic next_bit(output bit b);
        b = gen[TA-1] ^ gen[TB-1];
        gen = {gen[TB-2:0], b};
    endtask

    task automatic cycle(input bit v, input bit b, input bit clr);
        valid = v; bit_in = b; clear_counters = clr;
        @(posedge clock);
        model_step(v, b, clr);
        @(negedge clock);
        check_all();
    endtask

    // A valid bit consumes the next PRBS bit (optionally inverted); an idle cycle drives noise.
    task automatic send(input bit v, input bit flip, input bit clr);
        bit b;
        if (v) begin
            next_bit(b);
            cycle(1'b1, b ^ flip, clr);
        end else cycle(1'b0, 1'($urandom_range(0, 1)), clr);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        chk("reset_locked_now", locked, 0);
        chk("reset_bit_count_now", bit_count, 0);
        @(negedge clock);
        valid = 1'b0; clear_counters = 1'b0; reset = 1'b1;
    endtask

    task automatic relock(input bit rnd, output int nv);
        bit v;
        nv = 0;
        for (int k = 0; k < 3000 && !locked; k++) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            send(v, 1'b0, 1'b0);
            nv += int'(v);
        end
    endtask

    typedef struct {
        bit v, flip, clr;
        bit err;
        int bc, ec;
        bit sat;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   lock_at, pulses, nv, ll_cnt;
        bit   ever_locked;

        tbl[0] = '{1, 0, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 1, 0, 0};
        tbl[2] = '{1, 1, 0, 1, 2, 1, 0};
        tbl[3] = '{1, 0, 1, 0, 0, 0, 0};
        tbl[4] = '{1, 0, 0, 0, 1, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 1, 0, 0};
        tbl[6] = '{1, 0, 0, 0, 2, 0, 0};
        tbl[7] = '{1, 1, 1, 1, 0, 0, 0};

        model_reset();
        gen = 31'd1;
        @(negedge clock);
        check_all();
        reset = 1'b1;

        // Clean PRBS31: the lock-triggering bit is the 95th, so locked shows in the 96th clock.
        lock_at = 0;
        for (int i = 1; i <= 10000; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (lock_at == 0 && locked) lock_at = i;
        end
        chk("lock_latency_bits", lock_at, 95);
        chk("clean_error_count", error_count, 0);
        chk("clean_bit_count", bit_count, 10000 - 95);

        // Single line error after lock.
        send(1'b1, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 101; i++) begin
            send(1'b1, i == 50, 1'b0);
            pulses += int'(error);
            if (i == 50) chk("error_pulse_latency", error, 1);
        end
        chk("single_error_pulses", pulses, 1);
        chk("single_error_count", error_count, 1);
        chk("single_error_still_locked", locked, 1);

        // Reset mid-lock, then relock with valid toggling at random.
        chk("locked_before_reset", locked, 1);
        do_reset();
        relock(1'b1, nv);
        chk("relock_random_valid_bits", nv, 95);
        chk("relock_random_error_count", error_count, 0);

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].v, tbl[i].flip, tbl[i].clr);
            chk($sformatf("tbl%0d_error", i), error4, tbl[i].err);
            chk($sformatf("tbl%0d_bit_count4", i), bit_count4, tbl[i].bc);
            chk($sformatf("tbl%0d_error_count4", i), error_count4, tbl[i].ec);
            chk($sformatf("tbl%0d_saturated4", i), saturated4, tbl[i].sat);
        end

        send(1'b1, 1'b0, 1'b1);
        repeat (20) send(1'b1, 1'b0, 1'b0);
        chk("sat_bit_count4", bit_count4, 15);
        chk("sat_flag4", saturated4, 1);
        chk("no_sat_main", saturated, 0);
        send(1'b1, 1'b0, 1'b1);
        chk("clear_beats_increment", bit_count4, 0);
        chk("clear_drops_saturated", saturated4, 0);

        // Burst of 16 errors inside one window forces loss of lock on the 16th.
        do_reset();
        relock(1'b0, nv);
        chk("relock_before_burst", nv, 95);
        ll_cnt = 0;
        for (int k = 1; k <= 128; k++) begin
            send(1'b1, k % 8 == 0, 1'b0);
            ll_cnt += int'(lock_lost);
            if (k == 128) chk("lock_lost_on_16th", lock_lost, 1);
        end
        chk("lock_lost_pulses", ll_cnt, 1);
        chk("unlocked_after_burst", locked, 0);
        chk("burst_error_count", error_count, 16);
        send(1'b1, 1'b0, 1'b0);
        chk("lock_lost_one_cycle", lock_lost, 0);
        relock(1'b0, nv);
        chk("relock_after_burst", nv, 94);

        // Constant zero stream must never lock.
        do_reset();
        ever_locked = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            ever_locked |= locked;
        end
        chk("zero_stream_never_locks", ever_locked, 0);

        // Randomised traffic: gaps, sparse line errors, occasional clears, one mid-run reset.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            send(1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0, $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
